// File: rtl/sweep_sequencer_pkg.sv
// Shared definitions for the sweep calibration sequencer: FSM state encodings,
// default widths and servo axis select values.
package sweep_pkg;

   localparam int unsigned STEP_W_DFLT  = 4;
   localparam int unsigned LIGHT_W_DFLT = 8;

   typedef logic [2:0] state_t;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_H_SWEEP  = 3'd1;
   localparam logic [2:0] ST_H_RETURN = 3'd2;
   localparam logic [2:0] ST_V_SWEEP  = 3'd3;
   localparam logic [2:0] ST_V_RETURN = 3'd4;
   localparam logic [2:0] ST_FINISH   = 3'd5;

   localparam logic AXIS_H = 1'b0;
   localparam logic AXIS_V = 1'b1;

   // The vertical servo stays addressed from its sweep through the completion pulse.
   function automatic logic is_v_phase(input state_t st);
      return (st == ST_V_SWEEP) || (st == ST_V_RETURN) || (st == ST_FINISH);
   endfunction

endpackage

// File: rtl/sweep_sequencer_peak_tracker.sv
// Brightest-sample tracker shared by both sweep axes; clear re-arms it between sweeps.
// best_idx_next exposes the value best_idx takes at the coming edge.
module peak_tracker #(
   parameter int unsigned LIGHT_W = 8,
   parameter int unsigned STEP_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               sample_en,
   input  logic [LIGHT_W-1:0] light,
   input  logic [STEP_W-1:0]  idx,
   output logic [STEP_W-1:0]  best_idx,
   output logic [STEP_W-1:0]  best_idx_next
);
   import sweep_pkg::*;

   logic [LIGHT_W-1:0] best_q;
   logic [LIGHT_W-1:0] best_d;
   logic [STEP_W-1:0]  best_idx_q;
   logic [STEP_W-1:0]  best_idx_d;

   // Strict compare so that ties keep the earliest index.
   always_comb begin
      best_d     = best_q;
      best_idx_d = best_idx_q;
      if (clear) begin
         best_d     = '0;
         best_idx_d = '0;
      end else if (sample_en && (light > best_q)) begin
         best_d     = light;
         best_idx_d = idx;
      end else begin
         best_d     = best_q;
         best_idx_d = best_idx_q;
      end
   end

   // Peak value and index registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         best_q     <= '0;
         best_idx_q <= '0;
      end else begin
         best_q     <= best_d;
         best_idx_q <= best_idx_d;
      end
   end

   assign best_idx      = best_idx_q;
   assign best_idx_next = best_idx_d;

endmodule

// File: rtl/sweep_sequencer.sv
// Servo calibration sequencer: horizontal then vertical sweep, return to the brightest step.
// Optional phase watchdog with abort/ERR is enabled by defining SWEEP_TIMEOUT_EN.
module sweep_sequencer #(
   parameter int unsigned LIGHT_W = sweep_pkg::LIGHT_W_DFLT,
   parameter int unsigned STEP_W  = sweep_pkg::STEP_W_DFLT,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               CNT_H,
   input  logic               CNT_D,
   input  logic [LIGHT_W-1:0] LIGHT,
   output logic               HS,
   output logic               VS,
   output logic               STEP_P,
   output logic               STEP_N,
   output logic               AXIS_V,
   output logic [STEP_W-1:0]  POS_H,
   output logic [STEP_W-1:0]  POS_V,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR
);
   import sweep_pkg::*;

   localparam logic [STEP_W-1:0] IDX_ONE = {{(STEP_W-1){1'b0}}, 1'b1};
   localparam logic [STEP_W-1:0] IDX_MAX = {STEP_W{1'b1}};

   state_t              state_q, state_d;
   logic [STEP_W-1:0]   idx_q, idx_d;
   logic                armed_q, armed_d;
   logic [STEP_W-1:0]   pos_h_q, pos_h_d;
   logic [STEP_W-1:0]   pos_v_q, pos_v_d;
   logic                err_q, err_d;
   logic                hs_q, hs_d;
   logic                vs_q, vs_d;
   logic                step_p_q, step_p_d;
   logic                step_n_q, step_n_d;
   logic                axis_v_q, axis_v_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                en_s;
   logic                trk_clear_s;
   logic                trk_sample_s;
   logic [STEP_W-1:0]   best_idx_s;
   logic [STEP_W-1:0]   best_idx_next_s;
   logic                phase_expired_s;

   peak_tracker #(
      .LIGHT_W (LIGHT_W),
      .STEP_W  (STEP_W)
   ) u_peak (
      .clk           (CLK),
      .rst           (RST),
      .clear         (trk_clear_s),
      .sample_en     (trk_sample_s),
      .light         (LIGHT),
      .idx           (idx_q),
      .best_idx      (best_idx_s),
      .best_idx_next (best_idx_next_s)
   );

`ifdef SWEEP_TIMEOUT_EN
   localparam int unsigned PH_W = $clog2(TIMEOUT) + 1;
   localparam logic [PH_W-1:0] PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(TIMEOUT - 1);

   logic [PH_W-1:0] ph_cnt_q, ph_cnt_d;

   assign phase_expired_s = (ph_cnt_q == PH_LAST);

   // Phase cycle counter: reloads on every state change, idles at zero.
   always_comb begin
      ph_cnt_d = ph_cnt_q;
      if ((state_d != state_q) || (state_q == ST_IDLE)) begin
         ph_cnt_d = '0;
      end else if (!phase_expired_s) begin
         ph_cnt_d = ph_cnt_q + PH_ONE;
      end else begin
         ph_cnt_d = ph_cnt_q;
      end
   end

   // Phase counter register.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ph_cnt_q <= '0;
      end else begin
         ph_cnt_q <= ph_cnt_d;
      end
   end
`else
   logic unused_timeout_s;

   assign unused_timeout_s = (TIMEOUT > 0);
   assign phase_expired_s  = 1'b0;
`endif

   assign en_s = (state_q == ST_V_SWEEP) ? CNT_D : CNT_H;

   // Sequencer next-state, step index and position latching.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      armed_d      = armed_q;
      pos_h_d      = pos_h_q;
      pos_v_d      = pos_v_q;
      err_d        = err_q;
      trk_clear_s  = 1'b0;
      trk_sample_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               state_d     = ST_H_SWEEP;
               idx_d       = '0;
               armed_d     = 1'b0;
               err_d       = 1'b0;
               trk_clear_s = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_H_SWEEP, ST_V_SWEEP: begin
            trk_sample_s = 1'b1;
            idx_d        = (idx_q == IDX_MAX) ? idx_q : (idx_q + IDX_ONE);
            armed_d      = armed_q | en_s;
            // The enable must be seen high before its low level counts as end-of-sweep.
            if (armed_q && !en_s) begin
               state_d = (state_q == ST_H_SWEEP) ? ST_H_RETURN : ST_V_RETURN;
            end else if (phase_expired_s) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         ST_H_RETURN, ST_V_RETURN: begin
            if (idx_q == best_idx_s) begin
               idx_d       = '0;
               armed_d     = 1'b0;
               trk_clear_s = 1'b1;
               if (state_q == ST_H_RETURN) begin
                  pos_h_d = best_idx_s;
                  state_d = ST_V_SWEEP;
               end else begin
                  pos_v_d = best_idx_s;
                  state_d = ST_FINISH;
               end
            end else if (phase_expired_s) begin
               state_d = ST_IDLE;
               err_d   = 1'b1;
            end else begin
               idx_d = idx_q - IDX_ONE;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from next-state values so each is a plain flop.
   always_comb begin
      hs_d     = (state_d == ST_H_SWEEP);
      vs_d     = (state_d == ST_V_SWEEP);
      step_p_d = hs_d | vs_d;
      step_n_d = ((state_d == ST_H_RETURN) || (state_d == ST_V_RETURN)) &&
                 (idx_d > best_idx_next_s);
      axis_v_d = is_v_phase(state_d) ? sweep_pkg::AXIS_V : sweep_pkg::AXIS_H;
      busy_d   = (state_d != ST_IDLE);
      done_d   = (state_d == ST_FINISH);
   end

   // State and output registers.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         armed_q  <= 1'b0;
         pos_h_q  <= '0;
         pos_v_q  <= '0;
         err_q    <= 1'b0;
         hs_q     <= 1'b0;
         vs_q     <= 1'b0;
         step_p_q <= 1'b0;
         step_n_q <= 1'b0;
         axis_v_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         armed_q  <= armed_d;
         pos_h_q  <= pos_h_d;
         pos_v_q  <= pos_v_d;
         err_q    <= err_d;
         hs_q     <= hs_d;
         vs_q     <= vs_d;
         step_p_q <= step_p_d;
         step_n_q <= step_n_d;
         axis_v_q <= axis_v_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign HS     = hs_q;
   assign VS     = vs_q;
   assign STEP_P = step_p_q;
   assign STEP_N = step_n_q;
   assign AXIS_V = axis_v_q;
   assign POS_H  = pos_h_q;
   assign POS_V  = pos_v_q;
   assign BUSY   = busy_q;
   assign DONE   = done_q;
   assign ERR    = err_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Self-checking bench for sweep_sequencer: directed scenarios plus randomized sweeps
// checked against a peak-search reference model.
`timescale 1ns/1ps
module tb_sweep_sequencer;
   localparam int IDX_MAX = 15;
   localparam int NL      = 40;

   logic       CLK = 1'b0;
   logic       RST, START, CNT_H, CNT_D;
   logic [7:0] LIGHT;
   logic       HS, VS, STEP_P, STEP_N, AXIS_V, BUSY, DONE, ERR;
   logic [3:0] POS_H, POS_V;

   sweep_sequencer #(.LIGHT_W(8), .STEP_W(4), .TIMEOUT(64)) dut (
      .CLK(CLK), .RST(RST), .START(START), .CNT_H(CNT_H), .CNT_D(CNT_D), .LIGHT(LIGHT),
      .HS(HS), .VS(VS), .STEP_P(STEP_P), .STEP_N(STEP_N), .AXIS_V(AXIS_V),
      .POS_H(POS_H), .POS_V(POS_V), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   int passed = 0;
   int total  = 0;
   int lh [NL];
   int lv [NL];
   int r_hp, r_vp, r_hn, r_vn, r_hret, r_vret, r_done, r_both, r_axis_bad;
   int r_posh, r_posv, r_gap, r_vs_cycles;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) begin
         passed++;
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: first strictly-largest sample, indexed by the saturating step position.
   function automatic int ref_best(input int n, input bit is_v);
      int best;
      int bi;
      int v;
      best = 0;
      bi   = 0;
      for (int c = 0; c < n; c++) begin
         v = is_v ? lv[c] : lh[c];
         if (v > best) begin
            best = v;
            bi   = (c > IDX_MAX) ? IDX_MAX : c;
         end
      end
      return bi;
   endfunction

   function automatic int final_idx(input int n);
      return (n > IDX_MAX) ? IDX_MAX : n;
   endfunction

   task automatic fill(input int hmax, input int vmax);
      for (int i = 0; i < NL; i++) begin
         lh[i] = $urandom_range(hmax, 0);
         lv[i] = $urandom_range(vmax, 0);
      end
   endtask

   // One START-to-idle calibration; counter enables rise after 'a' sweep cycles and stay high 'l' cycles.
   task automatic run_cal(input int ha, input int hl, input int va, input int vl,
                          input bit v_stuck, input bit poke_start);
      int hc;
      int vc;
      int done_at;
      bit ended;
      hc = 0; vc = 0; done_at = -100; ended = 1'b0;
      r_hp = 0; r_vp = 0; r_hn = 0; r_vn = 0; r_hret = 0; r_vret = 0; r_done = 0;
      r_both = 0; r_axis_bad = 0; r_posh = -1; r_posv = -1; r_gap = -1; r_vs_cycles = 0;
      @(negedge CLK);
      START = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge CLK);
         START = 1'b0;
         if (cyc == 0) chk("busy_after_start", BUSY, 1);
         if (!BUSY) begin
            r_gap = cyc - done_at;
            ended = 1'b1;
            break;
         end
         LIGHT = 8'($urandom_range(255, 0));
         CNT_H = 1'b0;
         CNT_D = 1'b0;
         if (HS) begin
            CNT_H = (hc >= ha) && (hc < ha + hl);
            LIGHT = 8'(lh[(hc < NL) ? hc : NL - 1]);
            r_hp += int'(STEP_P);
            if (AXIS_V) r_axis_bad++;
            hc++;
         end
         if (VS) begin
            CNT_D = !v_stuck && (vc >= va) && (vc < va + vl);
            LIGHT = 8'(lv[(vc < NL) ? vc : NL - 1]);
            if (poke_start && (vc == 2)) START = 1'b1;
            r_vp += int'(STEP_P);
            r_vs_cycles++;
            if (!AXIS_V) r_axis_bad++;
            vc++;
         end
         if (STEP_N && !AXIS_V) r_hn++;
         if (STEP_N && AXIS_V) r_vn++;
         if (STEP_P && STEP_N) r_both++;
         if (!HS && !VS && !AXIS_V) r_hret++;
         if (!VS && AXIS_V && !DONE) r_vret++;
         if (DONE) begin
            r_done++;
            r_posh  = int'(POS_H);
            r_posv  = int'(POS_V);
            done_at = cyc;
         end
      end
      CNT_H = 1'b0;
      CNT_D = 1'b0;
      START = 1'b0;
      chk("run_terminated", ended, 1);
   endtask

   task automatic check_run(input string nm, input int ha, input int hl, input int va, input int vl);
      int nh, nv, bh, bv, sh, sv;
      nh = ha + hl + 1;
      nv = va + vl + 1;
      bh = ref_best(nh, 1'b0);
      bv = ref_best(nv, 1'b1);
      sh = final_idx(nh) - bh;
      sv = final_idx(nv) - bv;
      chk({nm, ".pos_h"}, r_posh, bh);
      chk({nm, ".pos_v"}, r_posv, bv);
      chk({nm, ".h_step_p"}, r_hp, nh);
      chk({nm, ".v_step_p"}, r_vp, nv);
      chk({nm, ".h_step_n"}, r_hn, sh);
      chk({nm, ".v_step_n"}, r_vn, sv);
      chk({nm, ".h_ret_cycles"}, r_hret, sh + 1);
      chk({nm, ".v_ret_cycles"}, r_vret, sv + 1);
      chk({nm, ".done_count"}, r_done, 1);
      chk({nm, ".done_to_idle"}, r_gap, 1);
      chk({nm, ".step_overlap"}, r_both, 0);
      chk({nm, ".axis_sel"}, r_axis_bad, 0);
      chk({nm, ".err"}, ERR, 0);
   endtask

   initial begin
      int ha, hl, va, vl;
      RST = 1'b1; START = 1'b0; CNT_H = 1'b0; CNT_D = 1'b0; LIGHT = 8'd0;
      repeat (2) @(negedge CLK);
      chk("reset_outputs", {HS, VS, STEP_P, STEP_N, AXIS_V, POS_H, POS_V, BUSY, DONE, ERR}, 0);
      RST = 1'b0;
      repeat (2) @(negedge CLK);
      chk("idle_busy", BUSY, 0);

      // Asynchronous reset in the middle of the horizontal sweep.
      START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      CNT_H = 1'b1;
      repeat (3) @(negedge CLK);
      chk("hs_before_rst", HS, 1);
      #2 RST = 1'b1;
      #1 chk("async_rst_outs", {HS, VS, STEP_P, STEP_N, BUSY}, 0);
      @(negedge CLK);
      RST = 1'b0;
      CNT_H = 1'b0;
      repeat (3) @(negedge CLK);
      chk("idle_after_rst", {HS, BUSY, DONE}, 0);

      // Full run with known peaks.
      fill(199, 179);
      lh[9] = 200;
      lv[3] = 180;
      run_cal(0, 15, 0, 15, 1'b0, 1'b0);
      chk("full.pos_h_9", r_posh, 9);
      chk("full.pos_v_3", r_posv, 3);
      chk("full.h_step_n_6", r_hn, 6);
      chk("full.v_step_n_12", r_vn, 12);
      check_run("full", 0, 15, 0, 15);

      // Tie keeps the earlier index.
      fill(99, 99);
      lh[2] = 100;
      lh[7] = 100;
      run_cal(0, 15, 1, 6, 1'b0, 1'b0);
      chk("tie.pos_h_2", r_posh, 2);
      check_run("tie", 0, 15, 1, 6);

      // Peak at the final index needs no return steps.
      fill(254, 254);
      lh[15] = 255;
      run_cal(0, 15, 2, 4, 1'b0, 1'b0);
      chk("last.h_step_n_0", r_hn, 0);
      check_run("last", 0, 15, 2, 4);

      // START during the vertical sweep is ignored.
      fill(255, 255);
      run_cal(1, 8, 0, 9, 1'b0, 1'b1);
      check_run("poke", 1, 8, 0, 9);
      repeat (4) @(negedge CLK);
      chk("poke.stays_idle", BUSY, 0);

      // Randomized sweeps, some with narrow light ranges to force ties.
      for (int k = 0; k < 5; k++) begin
         ha = $urandom_range(4, 0);
         hl = $urandom_range(20, 1);
         va = $urandom_range(4, 0);
         vl = $urandom_range(20, 1);
         if (k < 2) fill(7, 7);
         else fill(255, 255);
         run_cal(ha, hl, va, vl, 1'b0, 1'b0);
         check_run($sformatf("rand%0d", k), ha, hl, va, vl);
      end

`ifdef SWEEP_TIMEOUT_EN
      // Vertical enable never rises: watchdog aborts after 64 cycles without DONE.
      fill(255, 255);
      run_cal(0, 10, 0, 0, 1'b1, 1'b0);
      chk("tmo.vs_cycles", r_vs_cycles, 64);
      chk("tmo.no_done", r_done, 0);
      chk("tmo.err", ERR, 1);
      chk("tmo.outs_low", {VS, HS, STEP_P, STEP_N}, 0);
      fill(255, 255);
      run_cal(2, 5, 1, 7, 1'b0, 1'b0);
      check_run("after_tmo", 2, 5, 1, 7);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
